stopwatch_timekeeper: RTL and testbench

//  Downstream consumer of the 100 Hz tick produced by the board-clock tick generator.

---
 rtl/stopwatch_timekeeper.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_timekeeper.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timekeeper.sv
// stopwatch_timekeeper: start/pause/clear stopwatch counting 100 Hz ticks as
// six BCD digits MM:SS.cc. Define STOPWATCH_LAP_EN to build the lap/freeze
// feature (adds the lap input and frozen output).
module stopwatch_timekeeper #(
    parameter bit WRAP     = 1'b1,
    parameter bit EDGE_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
`endif
    output logic [23:0] digits,
    output logic        running,
    output logic        overflow
`ifdef STOPWATCH_LAP_EN
    ,
    output logic        frozen
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [23:0] COUNT_MAX = 24'h995999;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] cnt_inc;
    logic        inc_carry;
    logic        ovf_q, ovf_d;
    logic        running_q;
    logic        ss_q, clr_q;
    logic        ss_edge, clr_edge;
    logic        terminal;
`ifdef STOPWATCH_LAP_EN
    logic        lap_q;
    logic        lap_edge;
    logic        frozen_q, frozen_d;
    logic [23:0] snap_q, snap_d;
`endif

    // Highest value each digit reaches before wrapping, c0 at index 0.
    function automatic logic [3:0] digit_max(input int unsigned idx);
        return (idx == 32'd3) ? 4'd5 : 4'd9;
    endfunction

    assign ss_edge  = start_stop & ~ss_q;
    assign clr_edge = clear & ~clr_q;
    assign terminal = (cnt_q == COUNT_MAX);
`ifdef STOPWATCH_LAP_EN
    assign lap_edge = lap & ~lap_q;
`endif

    // Button history registers for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q  <= EDGE_RST;
            clr_q <= EDGE_RST;
`ifdef STOPWATCH_LAP_EN
            lap_q <= EDGE_RST;
`endif
        end else begin
            ss_q  <= start_stop;
            clr_q <= clear;
`ifdef STOPWATCH_LAP_EN
            lap_q <= lap;
`endif
        end
    end

    // BCD increment with the whole carry chain resolved in one cycle.
    always_comb begin
        cnt_inc   = cnt_q;
        inc_carry = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (inc_carry) begin
                if (cnt_q[4*i +: 4] == digit_max(i)) begin
                    cnt_inc[4*i +: 4] = '0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
    end

    // Next state, count, overflow and lap snapshot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef STOPWATCH_LAP_EN
        frozen_d = frozen_q;
        snap_d   = snap_q;
`endif
        if (state_q == RUN && tick) begin
            if (terminal && !WRAP) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
`ifdef STOPWATCH_LAP_EN
        if (lap_edge) begin
            if (frozen_q) begin
                frozen_d = 1'b0;
            end else if (state_q == RUN) begin
                frozen_d = 1'b1;
                snap_d   = cnt_q;
            end
        end
`endif
        case (state_q)
            IDLE:    if (ss_edge) state_d = RUN;
            RUN:     if (ss_edge) state_d = PAUSE;
            PAUSE: begin
                if (clr_edge)     state_d = IDLE;
                else if (ss_edge) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        // IDLE never counts, so zeroing whenever the next state is IDLE
        // is the same as zeroing on entry.
        if (state_d == IDLE) begin
            cnt_d = '0;
            ovf_d = 1'b0;
`ifdef STOPWATCH_LAP_EN
            frozen_d = 1'b0;
`endif
        end
    end

    // State, count and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            frozen_q  <= 1'b0;
            snap_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == RUN);
`ifdef STOPWATCH_LAP_EN
            frozen_q  <= frozen_d;
            snap_q    <= snap_d;
`endif
        end
    end

    assign running  = running_q;
    assign overflow = ovf_q;
`ifdef STOPWATCH_LAP_EN
    assign frozen   = frozen_q;
    assign digits   = frozen_q ? snap_q : cnt_q;
`else
    assign digits   = cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Bench for stopwatch_timekeeper: a wrapping and a saturating instance share
// stimulus; an elapsed-centisecond model predicts both every cycle.
module tb_stopwatch_timekeeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] digits_w, digits_s;
    logic        running_w, running_s, overflow_w, overflow_s;
`ifdef STOPWATCH_LAP_EN
    logic        lap = 1'b0;
    logic        frozen_w, frozen_s;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: elapsed centiseconds plus mode flags.
    int   cs_w = 0, cs_s = 0, snap_w = 0, snap_s = 0;
    bit   ovf_s = 1'b0, frz = 1'b0, m_run = 1'b0, m_pause = 1'b0;
    bit   h_ss = 1'b1, h_cl = 1'b1, h_lp = 1'b1;
    logic [23:0] pre_bcd = '0;

    always #5 clk = ~clk;

    stopwatch_timekeeper #(.WRAP(1'b1), .EDGE_RST(1'b1)) dut_w (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .frozen(frozen_w),
`endif
        .digits(digits_w), .running(running_w), .overflow(overflow_w)
    );

    stopwatch_timekeeper #(.WRAP(1'b0), .EDGE_RST(1'b1)) dut_s (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .frozen(frozen_s),
`endif
        .digits(digits_s), .running(running_s), .overflow(overflow_s)
    );

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        logic [23:0] r;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        r[23:20] = 4'(m / 10);
        r[19:16] = 4'(m % 10);
        r[15:12] = 4'(s / 10);
        r[11:8]  = 4'(s % 10);
        r[7:4]   = 4'(c / 10);
        r[3:0]   = 4'(c % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model update from the stopwatch rules, evaluated at each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_w = 0; cs_s = 0; snap_w = 0; snap_s = 0;
            ovf_s = 0; frz = 0; m_run = 0; m_pause = 0;
            h_ss = 1; h_cl = 1; h_lp = 1;
        end else begin
            bit es, ec, el;
            es = start_stop & ~h_ss;
            ec = clear & ~h_cl;
`ifdef STOPWATCH_LAP_EN
            el = lap & ~h_lp;
            h_lp = lap;
`else
            el = 1'b0;
`endif
            h_ss = start_stop;
            h_cl = clear;
            if (el) begin
                if (frz) frz = 0;
                else if (m_run) begin
                    frz = 1; snap_w = cs_w; snap_s = cs_s;
                end
            end
            if (m_run && tick) begin
                cs_w = (cs_w + 1) % 600000;
                if (cs_s == 599999) ovf_s = 1;
                else cs_s = cs_s + 1;
            end
            if (m_run) begin
                if (es) begin m_run = 0; m_pause = 1; end
            end else if (m_pause) begin
                if (ec) m_pause = 0;
                else if (es) begin m_pause = 0; m_run = 1; end
            end else if (es) begin
                m_run = 1;
            end
            if (!m_run && !m_pause) begin
                cs_w = 0; cs_s = 0; ovf_s = 0; frz = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("w.digits", digits_w, to_bcd(frz ? snap_w : cs_w));
        check("s.digits", digits_s, to_bcd(frz ? snap_s : cs_s));
        check("w.running", {23'd0, running_w}, {23'd0, m_run});
        check("s.running", {23'd0, running_s}, {23'd0, m_run});
        check("w.overflow", {23'd0, overflow_w}, 24'd0);
        check("s.overflow", {23'd0, overflow_s}, {23'd0, ovf_s});
`ifdef STOPWATCH_LAP_EN
        check("w.frozen", {23'd0, frozen_w}, {23'd0, frz});
        check("s.frozen", {23'd0, frozen_s}, {23'd0, frz});
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press_ss();
        start_stop = 1'b1; step(1); start_stop = 1'b0; step(1);
    endtask

    task automatic press_clr();
        clear = 1'b1; step(1); clear = 1'b0; step(1);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1; step(n); tick = 1'b0;
    endtask

    // Both instances are paused when loaded; holding the force across an
    // edge lets the register capture the value before release.
    task automatic preload(input int cs);
        pre_bcd = to_bcd(cs);
        force dut_w.cnt_q = pre_bcd;
        force dut_s.cnt_q = pre_bcd;
        cs_w = cs;
        cs_s = cs;
        step(1);
        release dut_w.cnt_q;
        release dut_s.cnt_q;
        step(1);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);
        check("reset digits", digits_w, 24'h000000);
        check("reset running", {23'd0, running_w}, 24'd0);

        // T1
        press_ss();
        ticks(150);
        check("T1 digits", digits_w, 24'h000150);
        check("T1 model", to_bcd(cs_w), 24'h000150);
        check("T1 running", {23'd0, running_w}, 24'd1);
        press_ss();
        ticks(10);
        step(1);
        check("T1 paused digits", digits_w, 24'h000150);
        check("T1 paused running", {23'd0, running_w}, 24'd0);

        // T4
        press_ss();
        press_clr();
        ticks(5);
        check("T4 clear ignored", digits_w, 24'h000155);
        press_ss();
        start_stop = 1'b1; clear = 1'b1; step(1);
        start_stop = 1'b0; clear = 1'b0; step(1);
        check("T4 both edges digits", digits_w, 24'h000000);
        check("T4 both edges running", {23'd0, running_w}, 24'd0);

        // T2
        press_ss();
        ticks(5999);
        check("T2 59.99", digits_w, 24'h005999);
        ticks(1);
        check("T2 1:00.00", digits_w, 24'h010000);
        press_ss();
        preload(59999);
        press_ss();
        ticks(1);
        check("T2 10:00.00", digits_s, 24'h100000);
        check("T2 model", to_bcd(cs_w), 24'h100000);
        press_ss();

        // T3
        preload(599999);
        press_ss();
        ticks(1);
        check("T3 wrap digits", digits_w, 24'h000000);
        check("T3 wrap ovf", {23'd0, overflow_w}, 24'd0);
        check("T3 sat digits", digits_s, 24'h995999);
        check("T3 sat ovf", {23'd0, overflow_s}, 24'd1);
        ticks(3);
        check("T3 wrap continues", digits_w, 24'h000003);
        check("T3 sat holds", digits_s, 24'h995999);
        check("T3 sat running", {23'd0, running_s}, 24'd1);
        press_ss();
        press_clr();
        check("T3 clear digits", digits_s, 24'h000000);
        check("T3 clear ovf", {23'd0, overflow_s}, 24'd0);

        // T5
        start_stop = 1'b1;
        rst = 1'b1; step(2);
        rst = 1'b0; step(2);
        check("T5 held through reset", {23'd0, running_w}, 24'd0);
        start_stop = 1'b0; step(1);
        start_stop = 1'b1; tick = 1'b1; step(1);
        start_stop = 1'b0; tick = 1'b0; step(1);
        check("T5 start tick ignored", digits_w, 24'h000000);
        check("T5 started", {23'd0, running_w}, 24'd1);
        tick = 1'b1; step(5);
        start_stop = 1'b1; step(1);
        start_stop = 1'b0; tick = 1'b0; step(1);
        check("T5 pause tick counted", digits_w, 24'h000006);
        check("T5 paused", {23'd0, running_w}, 24'd0);

`ifdef STOPWATCH_LAP_EN
        // T6
        press_clr();
        press_ss();
        ticks(200);
        lap = 1'b1; step(1); lap = 1'b0; step(1);
        check("T6 frozen", {23'd0, frozen_w}, 24'd1);
        check("T6 snapshot", digits_w, 24'h000200);
        ticks(300);
        check("T6 held", digits_w, 24'h000200);
        lap = 1'b1; step(1); lap = 1'b0; step(1);
        check("T6 unfrozen", {23'd0, frozen_w}, 24'd0);
        check("T6 live", digits_w, 24'h000500);
`endif

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
